// File: rtl/window_scan_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : window_scan_ctrl
//  Brief    : Raster-order detection-window sequencer; emits per-window pixel
//             address beats, then the window's top-left position.
//  Revision : 1.0 - initial release
// ============================================================================
module window_scan_ctrl #(
    parameter int IMG_WIDTH     = 320,
    parameter int IMG_HEIGHT    = 240,
    parameter int WINDOW_WIDTH  = 25,
    parameter int WINDOW_HEIGHT = 25,
    parameter int STEP          = 1,
    localparam int W_ADDR       = $clog2(IMG_WIDTH*IMG_HEIGHT),
    localparam int W_X          = $clog2(IMG_WIDTH),
    localparam int W_Y          = $clog2(IMG_HEIGHT)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              busy,
    output logic              addr_valid,
    input  logic              addr_ready,
    output logic [W_ADDR-1:0] addr_data,
    output logic [1:0]        addr_eot,
    output logic              pos_valid,
    input  logic              pos_ready,
    output logic [W_X-1:0]    pos_x,
    output logic [W_Y-1:0]    pos_y,
    output logic              frame_done
);

    localparam int W_C = (WINDOW_WIDTH  > 1) ? $clog2(WINDOW_WIDTH)  : 1;
    localparam int W_R = (WINDOW_HEIGHT > 1) ? $clog2(WINDOW_HEIGHT) : 1;

    localparam logic [W_C-1:0]    C_LAST   = W_C'(WINDOW_WIDTH - 1);
    localparam logic [W_R-1:0]    R_LAST   = W_R'(WINDOW_HEIGHT - 1);
    localparam logic [W_X-1:0]    X_LAST   = W_X'(((IMG_WIDTH  - WINDOW_WIDTH)  / STEP) * STEP);
    localparam logic [W_Y-1:0]    Y_LAST   = W_Y'(((IMG_HEIGHT - WINDOW_HEIGHT) / STEP) * STEP);
    localparam logic [W_X-1:0]    X_INC    = W_X'(STEP);
    localparam logic [W_Y-1:0]    Y_INC    = W_Y'(STEP);
    localparam logic [W_ADDR-1:0] A_COL    = W_ADDR'(1);
    localparam logic [W_ADDR-1:0] A_ROW    = W_ADDR'(IMG_WIDTH - WINDOW_WIDTH + 1);
    localparam logic [W_ADDR-1:0] A_XSTEP  = W_ADDR'(STEP);
    localparam logic [W_ADDR-1:0] A_YSTEP  = W_ADDR'(STEP * IMG_WIDTH);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_SCAN = 2'd1;
    localparam logic [1:0] S_POS  = 2'd2;

    logic [1:0]        state_q, state_d;
    logic [W_X-1:0]    x0_q, x0_d;
    logic [W_Y-1:0]    y0_q, y0_d;
    logic [W_R-1:0]    r_q, r_d;
    logic [W_C-1:0]    c_q, c_d;
    logic [W_ADDR-1:0] addr_q, addr_d;
    logic [W_ADDR-1:0] win_base_q, win_base_d;
    logic [W_ADDR-1:0] row_base_q, row_base_d;
    logic              frame_done_q, frame_done_d;

    logic w_col_last;
    logic w_row_last;
    logic w_beat_acc;

    assign w_col_last = (c_q == C_LAST);
    assign w_row_last = (r_q == R_LAST);
    assign w_beat_acc = (state_q == S_SCAN) && addr_ready;

    // win_base tracks y0*IMG_WIDTH+x0 and row_base tracks y0*IMG_WIDTH, so
    // every window rebase is a single constant add.
    always_comb begin
        state_d      = state_q;
        x0_d         = x0_q;
        y0_d         = y0_q;
        r_d          = r_q;
        c_d          = c_q;
        addr_d       = addr_q;
        win_base_d   = win_base_q;
        row_base_d   = row_base_q;
        frame_done_d = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d    = S_SCAN;
                    x0_d       = '0;
                    y0_d       = '0;
                    r_d        = '0;
                    c_d        = '0;
                    addr_d     = '0;
                    win_base_d = '0;
                    row_base_d = '0;
                end
            end
            S_SCAN: begin
                if (w_beat_acc) begin
                    if (w_col_last) begin
                        c_d = '0;
                        if (w_row_last) begin
                            state_d = S_POS;
                        end else begin
                            r_d    = r_q + 1'b1;
                            addr_d = addr_q + A_ROW;
                        end
                    end else begin
                        c_d    = c_q + 1'b1;
                        addr_d = addr_q + A_COL;
                    end
                end
            end
            S_POS: begin
                if (pos_ready) begin
                    if ((x0_q == X_LAST) && (y0_q == Y_LAST)) begin
                        state_d      = S_IDLE;
                        frame_done_d = 1'b1;
                    end else begin
                        state_d = S_SCAN;
                        r_d     = '0;
                        c_d     = '0;
                        if (x0_q == X_LAST) begin
                            x0_d       = '0;
                            y0_d       = y0_q + Y_INC;
                            row_base_d = row_base_q + A_YSTEP;
                            win_base_d = row_base_q + A_YSTEP;
                            addr_d     = row_base_q + A_YSTEP;
                        end else begin
                            x0_d       = x0_q + X_INC;
                            win_base_d = win_base_q + A_XSTEP;
                            addr_d     = win_base_q + A_XSTEP;
                        end
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            x0_q         <= '0;
            y0_q         <= '0;
            r_q          <= '0;
            c_q          <= '0;
            addr_q       <= '0;
            win_base_q   <= '0;
            row_base_q   <= '0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            x0_q         <= x0_d;
            y0_q         <= y0_d;
            r_q          <= r_d;
            c_q          <= c_d;
            addr_q       <= addr_d;
            win_base_q   <= win_base_d;
            row_base_q   <= row_base_d;
            frame_done_q <= frame_done_d;
        end
    end

    // All outputs decode directly from registered state.
    assign busy        = (state_q != S_IDLE);
    assign addr_valid  = (state_q == S_SCAN);
    assign addr_data   = addr_q;
    assign addr_eot    = (state_q == S_SCAN) ? {w_row_last, w_col_last} : 2'b00;
    assign pos_valid   = (state_q == S_POS);
    assign pos_x       = x0_q;
    assign pos_y       = y0_q;
    assign frame_done  = frame_done_q;

endmodule
`default_nettype wire

// File: tb/tb_window_scan_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_window_scan_ctrl
//  Brief    : Scoreboard bench: 6x5 image, 3x3 window, STEP=1 and STEP=2.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_window_scan_ctrl;

    localparam int TW = 6;
    localparam int TH = 5;
    localparam int TWIN = 3;

    typedef struct packed {
        logic [4:0] a;
        logic [1:0] e;
    } beat_t;

    typedef struct packed {
        logic [2:0] x;
        logic [2:0] y;
        logic       last;
    } pos_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] start = '0;
    logic [1:0] addr_ready = '0;
    logic [1:0] pos_ready = '0;
    logic [1:0] busy, addr_valid, pos_valid, frame_done;
    logic [4:0] addr_data [2];
    logic [1:0] addr_eot  [2];
    logic [2:0] pos_x     [2];
    logic [2:0] pos_y     [2];

    beat_t qa0[$], qa1[$];
    pos_t  qp0[$], qp1[$];

    int n_asserts = 0;
    int n_fail    = 0;
    int beats_acc [2];
    int pwait     [2];
    logic [1:0] bp = '0;
    logic [1:0] a_stall = '0, p_stall = '0, fd_exp = '0;
    logic [4:0] h_addr [2];
    logic [1:0] h_eot  [2];
    logic [2:0] h_px   [2];
    logic [2:0] h_py   [2];

    always #5 clk = ~clk;

    window_scan_ctrl #(.IMG_WIDTH(TW), .IMG_HEIGHT(TH), .WINDOW_WIDTH(TWIN),
                       .WINDOW_HEIGHT(TWIN), .STEP(1)) dut_s1 (
        .clk(clk), .rst(rst), .start(start[0]), .busy(busy[0]),
        .addr_valid(addr_valid[0]), .addr_ready(addr_ready[0]),
        .addr_data(addr_data[0]), .addr_eot(addr_eot[0]),
        .pos_valid(pos_valid[0]), .pos_ready(pos_ready[0]),
        .pos_x(pos_x[0]), .pos_y(pos_y[0]), .frame_done(frame_done[0]));

    window_scan_ctrl #(.IMG_WIDTH(TW), .IMG_HEIGHT(TH), .WINDOW_WIDTH(TWIN),
                       .WINDOW_HEIGHT(TWIN), .STEP(2)) dut_s2 (
        .clk(clk), .rst(rst), .start(start[1]), .busy(busy[1]),
        .addr_valid(addr_valid[1]), .addr_ready(addr_ready[1]),
        .addr_data(addr_data[1]), .addr_eot(addr_eot[1]),
        .pos_valid(pos_valid[1]), .pos_ready(pos_ready[1]),
        .pos_x(pos_x[1]), .pos_y(pos_y[1]), .frame_done(frame_done[1]));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_asserts++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Expected beats and positions for one frame, from the window geometry.
    task automatic push_frame(input int k, input int step);
        beat_t b;
        pos_t  p;
        for (int y0 = 0; y0 + TWIN <= TH; y0 += step) begin
            for (int x0 = 0; x0 + TWIN <= TW; x0 += step) begin
                for (int r = 0; r < TWIN; r++) begin
                    for (int c = 0; c < TWIN; c++) begin
                        b.a = 5'((y0 + r) * TW + x0 + c);
                        b.e = {(r == TWIN - 1), (c == TWIN - 1)};
                        if (k == 0) qa0.push_back(b); else qa1.push_back(b);
                    end
                end
                p.x    = 3'(x0);
                p.y    = 3'(y0);
                p.last = (x0 + step + TWIN > TW) && (y0 + step + TWIN > TH);
                if (k == 0) qp0.push_back(p); else qp1.push_back(p);
            end
        end
    endtask

    task automatic mon(input int k);
        beat_t b;
        pos_t  p;
        logic  have;
        if (addr_valid[k] || pos_valid[k])
            chk("valid_exclusive", 32'(addr_valid[k] & pos_valid[k]), 0);
        if (a_stall[k]) begin
            chk("addr_hold_valid", 32'(addr_valid[k]), 1);
            chk("addr_hold_data", 32'(addr_data[k]), 32'(h_addr[k]));
            chk("addr_hold_eot", 32'(addr_eot[k]), 32'(h_eot[k]));
        end
        if (p_stall[k]) begin
            chk("pos_hold_valid", 32'(pos_valid[k]), 1);
            chk("pos_hold_x", 32'(pos_x[k]), 32'(h_px[k]));
            chk("pos_hold_y", 32'(pos_y[k]), 32'(h_py[k]));
        end
        if (frame_done[k] || fd_exp[k])
            chk("frame_done", 32'(frame_done[k]), 32'(fd_exp[k]));
        fd_exp[k] = 1'b0;
        if (addr_valid[k] && addr_ready[k]) begin
            have = 1'b0;
            b    = '0;
            if (k == 0) begin
                if (qa0.size() > 0) begin b = qa0.pop_front(); have = 1'b1; end
            end else begin
                if (qa1.size() > 0) begin b = qa1.pop_front(); have = 1'b1; end
            end
            chk("beat_expected", 32'(have), 1);
            if (have) begin
                chk("beat_addr", 32'(addr_data[k]), 32'(b.a));
                chk("beat_eot", 32'(addr_eot[k]), 32'(b.e));
            end
            beats_acc[k]++;
        end
        if (pos_valid[k] && pos_ready[k]) begin
            have = 1'b0;
            p    = '0;
            if (k == 0) begin
                if (qp0.size() > 0) begin p = qp0.pop_front(); have = 1'b1; end
            end else begin
                if (qp1.size() > 0) begin p = qp1.pop_front(); have = 1'b1; end
            end
            chk("pos_expected", 32'(have), 1);
            if (have) begin
                chk("pos_x", 32'(pos_x[k]), 32'(p.x));
                chk("pos_y", 32'(pos_y[k]), 32'(p.y));
                fd_exp[k] = p.last;
            end
        end
        a_stall[k] = addr_valid[k] && !addr_ready[k];
        p_stall[k] = pos_valid[k] && !pos_ready[k];
        h_addr[k]  = addr_data[k];
        h_eot[k]   = addr_eot[k];
        h_px[k]    = pos_x[k];
        h_py[k]    = pos_y[k];
    endtask

    always @(negedge clk) begin
        if (rst) begin
            qa0.delete(); qa1.delete(); qp0.delete(); qp1.delete();
            a_stall = '0;
            p_stall = '0;
            fd_exp  = '0;
        end else begin
            for (int k = 0; k < 2; k++) mon(k);
        end
    end

    // Ready driver: all-ones, or 50% addr_ready with pos_ready low 5 cycles.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            for (int k = 0; k < 2; k++) begin
                if (bp[k]) begin
                    addr_ready[k] = 1'($urandom_range(0, 1));
                    if (pos_valid[k]) begin
                        pos_ready[k] = (pwait[k] >= 5);
                        pwait[k]++;
                    end else begin
                        pos_ready[k] = 1'b0;
                        pwait[k]     = 0;
                    end
                end else begin
                    addr_ready[k] = 1'b1;
                    pos_ready[k]  = 1'b1;
                    pwait[k]      = 0;
                end
            end
        end
    end

    task automatic pulse_start(input int k);
        @(posedge clk); #1 start[k] = 1'b1;
        @(posedge clk); #1 start[k] = 1'b0;
    endtask

    task automatic start_chk(input int k);
        pulse_start(k);
        @(negedge clk);
        chk("first_beat_valid", 32'(addr_valid[k]), 1);
        chk("first_beat_addr", 32'(addr_data[k]), 0);
        chk("busy_after_start", 32'(busy[k]), 1);
    endtask

    task automatic wait_done(input int k, input int maxc, output int busy_cyc);
        logic seen;
        seen     = 1'b0;
        busy_cyc = 1;
        for (int i = 0; i < maxc && !seen; i++) begin
            @(negedge clk);
            if (busy[k]) busy_cyc++;
            if (frame_done[k]) seen = 1'b1;
        end
        chk("frame_done_seen", 32'(seen), 1);
        chk("idle_at_done", 32'(busy[k]), 0);
    endtask

    initial begin
        int bc;
        int base;
        logic hit;
        beats_acc[0] = 0; beats_acc[1] = 0;
        pwait[0] = 0; pwait[1] = 0;
        repeat (3) @(posedge clk);
        #1;
        for (int k = 0; k < 2; k++) begin
            chk("rst_busy", 32'(busy[k]), 0);
            chk("rst_addr_valid", 32'(addr_valid[k]), 0);
            chk("rst_pos_valid", 32'(pos_valid[k]), 0);
            chk("rst_frame_done", 32'(frame_done[k]), 0);
            chk("rst_addr_data", 32'(addr_data[k]), 0);
        end
        rst = 1'b0;

        // STEP=1 frame: 12 windows of 10 cycles each
        push_frame(0, 1);
        start_chk(0);
        wait_done(0, 400, bc);
        chk("frame_cycles_step1", 32'(bc), 120);

        // STEP=2 frame, then a second frame started right after frame_done
        push_frame(1, 2);
        start_chk(1);
        wait_done(1, 200, bc);
        chk("frame_cycles_step2", 32'(bc), 40);
        push_frame(1, 2);
        start_chk(1);
        wait_done(1, 200, bc);
        chk("frame_cycles_b2b", 32'(bc), 40);

        // Backpressure plus start pulses during SCAN and POS
        bp[0] = 1'b1;
        push_frame(0, 1);
        start_chk(0);
        base = beats_acc[0];
        for (int i = 0; i < 200 && beats_acc[0] < base + 4; i++) @(posedge clk);
        pulse_start(0);
        hit = 1'b0;
        for (int i = 0; i < 200 && !hit; i++) begin
            @(negedge clk);
            hit = pos_valid[0];
        end
        chk("reached_pos", 32'(hit), 1);
        pulse_start(0);
        wait_done(0, 2000, bc);
        bp[0] = 1'b0;
        repeat (20) @(posedge clk);

        // Asynchronous reset at beat 5 of window 3
        push_frame(0, 1);
        start_chk(0);
        base = beats_acc[0] - 1;
        hit  = 1'b0;
        for (int i = 0; i < 500 && !hit; i++) begin
            @(posedge clk);
            hit = (beats_acc[0] >= base + 3 * TWIN * TWIN + 5);
        end
        chk("reached_reset_point", 32'(hit), 1);
        #2 rst = 1'b1;
        #1;
        chk("arst_busy", 32'(busy[0]), 0);
        chk("arst_addr_valid", 32'(addr_valid[0]), 0);
        chk("arst_addr_data", 32'(addr_data[0]), 0);
        chk("arst_addr_eot", 32'(addr_eot[0]), 0);
        chk("arst_pos", 32'({pos_x[0], pos_y[0], pos_valid[0], frame_done[0]}), 0);
        @(negedge clk);
        @(posedge clk); #1 rst = 1'b0;
        repeat (5) @(posedge clk);
        chk("idle_after_reset", 32'(busy[0]), 0);
        push_frame(0, 1);
        start_chk(0);
        wait_done(0, 400, bc);
        chk("frame_cycles_after_reset", 32'(bc), 120);

        repeat (10) @(posedge clk);
        chk("beats_left_s1", qa0.size(), 0);
        chk("beats_left_s2", qa1.size(), 0);
        chk("pos_left_s1", qp0.size(), 0);
        chk("pos_left_s2", qp1.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: got 1 expected 0");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
